// File: rtl/blood_pkg.sv
// blood_pkg: shared blood-type encodings, widths and default class map for the classifier stream
package blood_pkg;
  localparam int BLOOD_TYPE_W = 3;
  localparam int RH_BIT = 0;
  typedef enum logic [1:0] {
    ABO_O  = 2'b00,
    ABO_A  = 2'b01,
    ABO_B  = 2'b10,
    ABO_AB = 2'b11
  } abo_e;
  localparam logic [15:0] DEF_CLASS_MAP = 16'hF5A0;
  // donor antigens must be a subset of recipient antigens, Rh included
  function automatic logic abo_rh_compat(input logic [BLOOD_TYPE_W-1:0] donor, input logic [BLOOD_TYPE_W-1:0] recip);
    abo_e d_abo, r_abo;
    d_abo = abo_e'(donor[2:1]);
    r_abo = abo_e'(recip[2:1]);
    return ((d_abo & ~r_abo) == ABO_O) && (!donor[RH_BIT] || recip[RH_BIT]);
  endfunction
endpackage

// File: rtl/blood_class_counters.sv
// blood_class_counters: per-class saturating counters with clear-then-count and combinational read mux
module blood_class_counters #(
  parameter int CLASS_W = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [CLASS_W-1:0] inc_sel,
  input  logic [CLASS_W-1:0] rd_sel,
  output logic [CNT_W-1:0]   rd_data
);
  localparam int NUM_CLASSES = 2**CLASS_W;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      hit = inc && (inc_sel == CLASS_W'(i));
      cnt_d[i] = clr ? (hit ? CNT_W'(1) : '0) :
                 (hit && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  assign rd_data = cnt_q[rd_sel];
endmodule

// File: rtl/blood_class_stream.sv
// blood_class_stream: valid/ready blood-type classifier with class counters and batch pulse; BLOOD_COMPAT_EN adds donor/recipient compatibility output
module blood_class_stream
  import blood_pkg::*;
#(
  parameter int CLASS_W = 2,
  parameter logic [8*CLASS_W-1:0] CLASS_MAP = DEF_CLASS_MAP,
  parameter int CNT_W = 8,
  parameter int BATCH_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOOD_TYPE_W-1:0] bloodType,
`ifdef BLOOD_COMPAT_EN
  input  logic [BLOOD_TYPE_W-1:0] recipType,
  output logic                    compatible,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CLASS_W-1:0]      bloodClass,
  input  logic                    clr_counts,
  input  logic [CLASS_W-1:0]      cnt_sel,
  output logic [CNT_W-1:0]        cnt_data,
  output logic                    batch_done
);
  localparam int BW = BATCH_LEN > 1 ? $clog2(BATCH_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(BATCH_LEN - 1);
  logic               accept;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [CLASS_W-1:0] class_q, class_d, lut_class;
  logic [BW-1:0]      bcnt_q, bcnt_d, bcnt_base;
  assign in_ready = !valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign lut_class = CLASS_MAP[bloodType*CLASS_W +: CLASS_W];
  // clear applies before the same-cycle accept is counted
  always_comb begin
    valid_d = accept || (valid_q && !out_ready);
    class_d = accept ? lut_class : class_q;
    bcnt_base = clr_counts ? '0 : bcnt_q;
    bcnt_d = !accept ? bcnt_base : (bcnt_base == LAST) ? '0 : bcnt_base + BW'(1);
    done_d = accept && (bcnt_base == LAST);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      class_q <= '0;
      bcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      class_q <= class_d;
      bcnt_q <= bcnt_d;
      done_q <= done_d;
    end
  end
`ifdef BLOOD_COMPAT_EN
  logic compat_q, compat_d;
  always_comb compat_d = accept ? abo_rh_compat(bloodType, recipType) : compat_q;
  always_ff @(posedge clk) begin
    if (rst) compat_q <= 1'b0;
    else compat_q <= compat_d;
  end
  assign compatible = compat_q;
`endif
  blood_class_counters #(
    .CLASS_W(CLASS_W),
    .CNT_W(CNT_W)
  ) u_counters (
    .clk(clk),
    .rst(rst),
    .clr(clr_counts),
    .inc(accept),
    .inc_sel(lut_class),
    .rd_sel(cnt_sel),
    .rd_data(cnt_data)
  );
  assign out_valid = valid_q;
  assign bloodClass = class_q;
  assign batch_done = done_q;
endmodule

// File: tb/tb_blood_class_stream.sv
// tb_blood_class_stream: three parameterisations driven in lockstep against a queue-free behavioural model plus directed tables
module tb_blood_class_stream;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr = 0;
  logic [2:0] bt = 0, rt = 0;
  logic [1:0] sel = 0;
  logic rdy [3], ov [3], bd [3];
  logic [1:0] bc [3];
  logic [7:0] cd0, cd2;
  logic [1:0] cd1;
`ifdef BLOOD_COMPAT_EN
  logic cp [3];
`endif
  always #5 clk = ~clk;

  blood_class_stream u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .bloodType(bt),
`ifdef BLOOD_COMPAT_EN
    .recipType(rt), .compatible(cp[0]),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .bloodClass(bc[0]), .clr_counts(clr),
    .cnt_sel(sel), .cnt_data(cd0), .batch_done(bd[0]));
  blood_class_stream #(.CNT_W(2), .BATCH_LEN(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .bloodType(bt),
`ifdef BLOOD_COMPAT_EN
    .recipType(rt), .compatible(cp[1]),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .bloodClass(bc[1]), .clr_counts(clr),
    .cnt_sel(sel), .cnt_data(cd1), .batch_done(bd[1]));
  blood_class_stream #(.BATCH_LEN(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .bloodType(bt),
`ifdef BLOOD_COMPAT_EN
    .recipType(rt), .compatible(cp[2]),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .bloodClass(bc[2]), .clr_counts(clr),
    .cnt_sel(sel), .cnt_data(cd2), .batch_done(bd[2]));

  typedef struct { logic [2:0] bt; logic [1:0] cls; } vec_t;
  typedef struct { logic [2:0] d; logic [2:0] r; logic ok; } cvec_t;
  vec_t tbl [8];
  cvec_t ctbl [4];

  int pass_n = 0, tot_n = 0;
  int map [8] = '{0, 0, 2, 2, 1, 1, 3, 3};
  int maxc [3] = '{255, 3, 255};
  int bl [3] = '{16, 4, 1};
  int mcnt [3][4];
  int mb [3];
  bit md [3];
  bit mv, mcp;
  int mc;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
  endtask

  function automatic int cdat(input int k);
    return k == 0 ? int'(cd0) : k == 1 ? int'(cd1) : int'(cd2);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), rdy[k], (!mv || out_ready));
      chk($sformatf("out_valid[%0d]", k), ov[k], mv);
      chk($sformatf("bloodClass[%0d]", k), bc[k], mc);
      chk($sformatf("batch_done[%0d]", k), bd[k], md[k]);
      chk($sformatf("cnt_data[%0d] sel %0d", k, sel), cdat(k), mcnt[k][sel]);
`ifdef BLOOD_COMPAT_EN
      chk($sformatf("compatible[%0d]", k), cp[k], mcp);
`endif
    end
  endtask

  task automatic model_update();
    bit acc;
    acc = in_valid && (!mv || out_ready);
    if (rst) begin
      mv = 0; mc = 0; mcp = 0;
      for (int k = 0; k < 3; k++) begin
        mb[k] = 0; md[k] = 0;
        for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (clr) begin
          mb[k] = 0;
          for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
        end
        md[k] = 0;
        if (acc) begin
          mcnt[k][map[bt]] = (mcnt[k][map[bt]] + 1 > maxc[k]) ? maxc[k] : mcnt[k][map[bt]] + 1;
          mb[k]++;
          if (mb[k] == bl[k]) begin mb[k] = 0; md[k] = 1; end
        end
      end
      if (acc) begin
        mv = 1; mc = map[bt];
        mcp = (bt[2] <= rt[2]) && (bt[1] <= rt[1]) && (bt[0] <= rt[0]);
      end else if (out_ready) mv = 0;
    end
  endtask

  task automatic step();
    #3 check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    int pulses;
    tbl = '{'{3'd0, 2'd0}, '{3'd1, 2'd0}, '{3'd2, 2'd2}, '{3'd3, 2'd2},
            '{3'd4, 2'd1}, '{3'd5, 2'd1}, '{3'd6, 2'd3}, '{3'd7, 2'd3}};
    ctbl = '{'{3'b000, 3'b111, 1'b1}, '{3'b011, 3'b001, 1'b0},
             '{3'b101, 3'b100, 1'b0}, '{3'b110, 3'b111, 1'b1}};
    for (int k = 0; k < 3; k++) begin
      mb[k] = 0; md[k] = 0;
      for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
    end
    mv = 0; mc = 0; mcp = 0;
    @(posedge clk); #1;
    step(); rst = 0;
    chk("reset out_valid", ov[0], 0);
    chk("reset bloodClass", bc[0], 0);
    chk("reset batch_done", bd[0], 0);
    // streaming table at full throughput
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      bt = tbl[i].bt;
      step();
      chk($sformatf("stream class type %0d", i), bc[0], tbl[i].cls);
      chk("stream in_ready", rdy[0], 1);
    end
    in_valid = 0;
    // stall and release
    do_reset();
    in_valid = 1; bt = 6; step();
    out_ready = 0; bt = 2;
    repeat (3) begin
      step();
      chk("stall in_ready", rdy[0], 0);
      chk("stall class held", bc[0], 3);
      chk("stall valid held", ov[0], 1);
    end
    out_ready = 1; step();
    chk("drain+accept class", bc[0], 2);
    chk("drain+accept valid", ov[0], 1);
    in_valid = 0; step();
    chk("no duplicate", ov[0], 0);
    chk("single count class2", cd0, (sel == 2) ? 1 : 0);
    // rst mid-stall
    in_valid = 1; bt = 7; step();
    out_ready = 0; in_valid = 0; step();
    chk("pre-rst valid", ov[0], 1);
    do_reset();
    chk("rst mid-stall valid", ov[0], 0);
    out_ready = 1;
    // saturation
    do_reset();
    in_valid = 1; bt = 6;
    repeat (5) step();
    in_valid = 0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      chk($sformatf("sat CNT_W=2 cnt[%0d]", s), cd1, (s == 3) ? 3 : 0);
      chk($sformatf("sat CNT_W=8 cnt[%0d]", s), cd0, (s == 3) ? 5 : 0);
    end
    step();
    // batches with gaps
    do_reset();
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid = (i % 2 == 0) && (i < 16);
      bt = 3'($urandom);
      step();
      if (bd[1]) pulses++;
    end
    chk("batch pulses", pulses, 2);
    // clear with same-cycle accept
    do_reset();
    in_valid = 1; bt = 0;
    repeat (3) step();
    clr = 1; bt = 4; step();
    clr = 0; in_valid = 0;
    chk("clr batch_done BL4", bd[1], 0);
    chk("clr batch_done BL1", bd[2], 1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      chk($sformatf("clr cnt[%0d]", s), cd1, (s == 1) ? 1 : 0);
    end
    step();
    in_valid = 1; bt = 5;
    repeat (2) step();
    chk("clr batch count 3", bd[1], 0);
    step();
    chk("clr batch count 4", bd[1], 1);
    in_valid = 0;
`ifdef BLOOD_COMPAT_EN
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bt = ctbl[i].d; rt = ctbl[i].r;
      step();
      chk($sformatf("compat case %0d", i), cp[0], ctbl[i].ok);
    end
    out_ready = 0; in_valid = 0; step();
    do_reset();
    chk("compat rst mid-stall valid", ov[0], 0);
    chk("compat rst value", cp[0], 0);
    out_ready = 1;
`endif
    // randomized traffic
    do_reset();
    repeat (3000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      bt = 3'($urandom);
      rt = 3'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 199) == 0);
      sel = 2'($urandom);
      step();
    end
    rst = 0; clr = 0; in_valid = 0;
    step();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
